// File: rtl/ysyx_25010008_ifu.sv
// Instruction fetch unit: holds the PC, issues one read per instruction, hands the word to the decoder.
// Latency: 4 cycles fetch-to-fetch (REQ, WAIT, ISSUE, EXEC) with zero-wait memory and same-cycle commit.
// Backpressure: arvalid/araddr held until arready; one read outstanding; stalls in EXEC until commit.
//
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   imem_arvalid/araddr/arready     read address channel (araddr always mirrors pc)
//   imem_rvalid/rdata/rresp/rready  read data channel (rready only while waiting for data)
//   inst, ivalid, pc                fetched word to the decoder, ivalid is a one-cycle pulse
//   commit, next_pc, halt           retirement of the current instruction from execute/writeback
//   halted, fetch_fault             terminal status flags, cleared only by reset
module ysyx_25010008_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_arvalid,
  output logic [31:0] imem_araddr,
  input  logic        imem_arready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  output logic        imem_rready,
  output logic [31:0] inst,
  output logic        ivalid,
  output logic [31:0] pc,
  input  logic        commit,
  input  logic [31:0] next_pc,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_fault
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;
  localparam logic [2:0] S_FAULT = 3'd6;

  // The wait timer is 8 bits wide: the last legal count is TIMEOUT-1,
  // clamped so that TIMEOUT values above 256 saturate at 255.
  localparam int unsigned TLIM_I = (TIMEOUT > 256) ? 255 :
                                   ((TIMEOUT < 1) ? 0 : (TIMEOUT - 1));
  localparam logic [7:0]  TLIM   = 8'(TLIM_I);

  logic [2:0]  state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [7:0]  timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pc_q   <= RESET_PC;
      inst_q <= '0;
      timer  <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (imem_arready) begin
            state <= S_WAIT;
            timer <= '0;
          end
        end

        S_WAIT: begin
          timer <= timer + 8'd1;
          // A response arriving on the timeout cycle still wins.
          if (imem_rvalid) begin
            if (imem_rresp == 2'b00) begin
              inst_q <= imem_rdata;
              state  <= S_ISSUE;
            end else begin
              state <= S_FAULT;
            end
          end else if (timer == TLIM) begin
            state <= S_FAULT;
          end
        end

        S_ISSUE: state <= S_EXEC;

        S_EXEC: begin
          if (commit) begin
            if (halt) begin
              state <= S_HALT;
            end else begin
              // pc takes the new target even when misaligned, so the
              // fault status reports the offending address.
              pc_q  <= next_pc;
              state <= (next_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
            end
          end
        end

        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;

        // Unreachable encoding: park in FAULT rather than fetch garbage.
        default: state <= S_FAULT;
      endcase
    end
  end

  assign imem_arvalid = (state == S_REQ);
  assign imem_araddr  = pc_q;
  assign imem_rready  = (state == S_WAIT);
  assign ivalid       = (state == S_ISSUE);
  assign inst         = inst_q;
  assign pc           = pc_q;
  assign halted       = (state == S_HALT);
  assign fetch_fault  = (state == S_FAULT);

endmodule

// File: tb/tb_ysyx_25010008_ifu.sv
// Bench for the instruction fetch unit: a reactive memory/execute environment,
// an abstract fetch model checked every cycle, and directed scenarios with literal expectations.
// Inputs change 1-2 time units after the falling edge; outputs are compared on the falling edge.
module tb_ysyx_25010008_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TIMEOUT  = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic [31:0] inst;
  logic        ivalid;
  logic [31:0] pc;
  logic        commit;
  logic [31:0] next_pc;
  logic        halt;
  logic        halted;
  logic        fetch_fault;

  ysyx_25010008_ifu #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr), .imem_arready(imem_arready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rresp(imem_rresp),
    .imem_rready(imem_rready),
    .inst(inst), .ivalid(ivalid), .pc(pc),
    .commit(commit), .next_pc(next_pc), .halt(halt),
    .halted(halted), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: the reset vector holds a NOP (addi x0,x0,0).
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == RESET_PC) ? 32'h0000_0013 : {a[15:0] ^ 16'h5a5a, 16'h0093};
  endfunction

  // ---------------- environment knobs ----------------
  int          ar_stall   = 0;     // cycles arready is held low per request
  int          r_lat      = 0;     // waiting cycles before rvalid
  bit          r_err      = 1'b0;  // respond with SLVERR
  bit          r_none     = 1'b0;  // never respond
  bit          junk       = 1'b0;  // spurious rvalid/commit/halt where they must be ignored
  bit          use_fixed  = 1'b0;  // commit nxt_fixed instead of pc+4
  logic [31:0] nxt_fixed  = 32'h0;
  bit          hlt_knob   = 1'b0;
  bit          commit_en  = 1'b1;
  int          commit_lat = 0;

  // ---------------- memory + execute environment ----------------
  int          stall_left = 0;
  int          lat_left   = 0;
  int          commit_left = 0;
  bit          in_exec    = 1'b0;
  logic [31:0] addr_q     = 32'h0;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      imem_arready = 1'b0;
      imem_rvalid  = 1'b0;
      imem_rdata   = 32'h0;
      imem_rresp   = 2'b00;
      commit       = 1'b0;
      halt         = 1'b0;
      next_pc      = 32'h0;
      stall_left   = ar_stall;
      lat_left     = r_lat;
      in_exec      = 1'b0;
      commit_left  = 0;
    end else begin
      if (!imem_arvalid) begin
        stall_left   = ar_stall;
        imem_arready = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        imem_arready = 1'b0;
      end else begin
        imem_arready = 1'b1;
        addr_q       = imem_araddr;
      end

      if (imem_rready) begin
        if (r_none || lat_left > 0) begin
          imem_rvalid = 1'b0;
          if (lat_left > 0) lat_left--;
        end else begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(addr_q);
          imem_rresp  = r_err ? 2'b10 : 2'b00;
        end
      end else begin
        lat_left    = r_lat;
        imem_rvalid = junk;
        imem_rdata  = 32'hdead_beef;
        imem_rresp  = 2'b11;
      end

      commit  = 1'b0;
      halt    = 1'b0;
      next_pc = 32'h0;
      if (in_exec) begin
        if (commit_left > 0) begin
          commit_left--;
          halt = junk;
        end else if (commit_en) begin
          commit  = 1'b1;
          halt    = hlt_knob;
          next_pc = use_fixed ? nxt_fixed : pc + 32'd4;
          in_exec = 1'b0;
        end
      end else if (junk) begin
        commit  = 1'b1;
        halt    = 1'b1;
        next_pc = 32'h0000_0001;
      end
      if (ivalid) begin
        in_exec     = 1'b1;
        commit_left = commit_lat;
      end
    end
  end

  // ---------------- abstract fetch model + per-cycle compare ----------------
  logic        p_arvalid = 1'b0;
  logic        p_ivalid  = 1'b0;
  logic [31:0] p_araddr  = 32'h0;
  logic [31:0] exp_pc    = RESET_PC;
  logic [31:0] exp_inst  = 32'h0;
  bit          busy = 1'b0, need_fetch = 1'b1, issued = 1'b0;
  bit          halted_m = 1'b0, fault_m = 1'b0;
  bit          ar_hs = 1'b0, r_ok = 1'b0, fetch_now = 1'b0;
  int          wait_cnt = 0, cyc = 0;
  int          first_ar_cyc = 0, fault_cyc = 0, n_hs = 0, ar_cycles = 0;
  logic [31:0] ar_log[$];
  int          iv_cyc[$];
  logic [31:0] iv_pc[$];
  logic [31:0] iv_inst[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_pc = RESET_PC; busy = 0; need_fetch = 1; issued = 0;
      halted_m = 0; fault_m = 0; wait_cnt = 0; cyc = 0;
      first_ar_cyc = 0; fault_cyc = 0; n_hs = 0; ar_cycles = 0;
      ar_log.delete(); iv_cyc.delete(); iv_pc.delete(); iv_inst.delete();
      p_arvalid = 1'b0; p_ivalid = 1'b0; p_araddr = RESET_PC;
    end else begin
      cyc++;
      // Events at the edge just past: DUT outputs before it, bench inputs applied at it.
      ar_hs = p_arvalid && imem_arready;
      r_ok  = 1'b0;
      fetch_now = 1'b0;
      if (busy && imem_rvalid) begin
        busy = 0;
        if (imem_rresp == 2'b00) begin
          r_ok     = 1'b1;
          exp_inst = memf(exp_pc);
        end else begin
          fault_m = 1;
        end
      end else if (busy) begin
        wait_cnt++;
        if (wait_cnt == TIMEOUT) begin
          busy    = 0;
          fault_m = 1;
        end
      end
      if (ar_hs) begin
        busy = 1; wait_cnt = 0; need_fetch = 0; n_hs++;
        ar_log.push_back(p_araddr);
      end
      if (issued && !p_ivalid && commit) begin
        issued = 0;
        if (halt) begin
          halted_m = 1;
        end else begin
          exp_pc = next_pc;
          if (next_pc[1:0] != 2'b00) fault_m = 1;
          else begin
            need_fetch = 1;
            fetch_now  = 1;
          end
        end
      end

      chk32("pc", pc, exp_pc);
      chk1("ivalid", ivalid, r_ok);
      if (r_ok || issued) chk32("inst", inst, exp_inst);
      chk1("rready", imem_rready, busy);
      chk1("halted", halted, halted_m);
      chk1("fetch_fault", fetch_fault, fault_m);
      chk1("arvalid_unexpected", imem_arvalid && !need_fetch, 1'b0);
      if (imem_arvalid) chk32("araddr", imem_araddr, exp_pc);
      if (p_arvalid && !imem_arready) begin
        chk1("arvalid_held", imem_arvalid, 1'b1);
        chk32("araddr_held", imem_araddr, p_araddr);
      end
      if (fetch_now) chk1("arvalid_after_commit", imem_arvalid, 1'b1);

      if (imem_arvalid && first_ar_cyc == 0) first_ar_cyc = cyc;
      if (imem_arvalid && n_hs == 0) ar_cycles++;
      if (fetch_fault && fault_cyc == 0) fault_cyc = cyc;
      if (ivalid) begin
        iv_cyc.push_back(cyc);
        iv_pc.push_back(pc);
        iv_inst.push_back(inst);
        issued = 1;
      end

      p_arvalid = imem_arvalid;
      p_araddr  = imem_araddr;
      p_ivalid  = ivalid;
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic knobs_default();
    ar_stall = 0; r_lat = 0; r_err = 0; r_none = 0; junk = 0;
    use_fixed = 0; nxt_fixed = 32'h0; hlt_knob = 0; commit_en = 1; commit_lat = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Release lands 2 units after a falling edge; the next falling edge is cycle 1.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk32("rst_pc", pc, RESET_PC);
    chk32("rst_araddr", imem_araddr, RESET_PC);
    chk32("rst_inst", inst, 32'h0);
    chk1("rst_arvalid", imem_arvalid, 1'b0);
    chk1("rst_rready", imem_rready, 1'b0);
    chk1("rst_ivalid", ivalid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk1("rst_fault", fetch_fault, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit saw_wait;

    // 1+2: zero-wait memory, immediate commit of pc+4, junk on ignored inputs.
    knobs_default();
    junk = 1;
    do_reset();
    run(20);
    chki("t1_first_arvalid_cycle", first_ar_cyc, 1);
    chki("t1_ivalid_count", iv_cyc.size(), 5);
    if (iv_cyc.size() >= 2 && ar_log.size() >= 2) begin
      chk32("t1_araddr0", ar_log[0], 32'h8000_0000);
      chk32("t1_inst0", iv_inst[0], 32'h0000_0013);
      chk32("t1_pc0", iv_pc[0], 32'h8000_0000);
      chki("t1_ivalid0_cycle", iv_cyc[0], 3);
      chk32("t2_araddr1", ar_log[1], 32'h8000_0004);
      chk32("t2_pc1", iv_pc[1], 32'h8000_0004);
      chki("t2_ivalid_spacing", iv_cyc[1] - iv_cyc[0], 4);
    end

    // 3: arready held low for 5 cycles.
    knobs_default();
    ar_stall = 5;
    do_reset();
    run(20);
    chki("t3_arvalid_cycles", ar_cycles, 6);
    chki("t3_ivalid0_cycle", iv_cyc.size() > 0 ? iv_cyc[0] : -1, 8);

    // 4a: error response on the first fetch.
    knobs_default();
    r_err = 1;
    do_reset();
    run(15);
    chk1("t4a_fault", fetch_fault, 1'b1);
    chk32("t4a_pc", pc, 32'h8000_0000);
    chki("t4a_ivalid_count", iv_cyc.size(), 0);
    chki("t4a_requests", n_hs, 1);
    chki("t4a_fault_cycle", fault_cyc, 3);

    // 4b: no response at all -> timeout after TIMEOUT waiting cycles.
    knobs_default();
    r_none = 1;
    do_reset();
    run(270);
    chk1("t4b_fault", fetch_fault, 1'b1);
    chki("t4b_fault_cycle", fault_cyc, 258);
    chki("t4b_requests", n_hs, 1);

    // 4c: response on the very last waiting cycle beats the timeout.
    knobs_default();
    r_lat = 255;
    do_reset();
    run(270);
    chk1("t4c_no_fault", fetch_fault, 1'b0);
    chki("t4c_ivalid0_cycle", iv_cyc.size() > 0 ? iv_cyc[0] : -1, 258);

    // 5a: halting commit.
    knobs_default();
    hlt_knob = 1;
    do_reset();
    run(15);
    chk1("t5a_halted", halted, 1'b1);
    chki("t5a_requests", n_hs, 1);
    chk32("t5a_pc", pc, 32'h8000_0000);

    // 5b: misaligned next_pc.
    knobs_default();
    use_fixed = 1;
    nxt_fixed = 32'h8000_0002;
    commit_lat = 2;
    do_reset();
    run(15);
    chk1("t5b_fault", fetch_fault, 1'b1);
    chk32("t5b_pc", pc, 32'h8000_0002);
    chki("t5b_requests", n_hs, 1);
    chki("t5b_fault_cycle", fault_cyc, 7);

    // 6: reset while waiting for read data.
    knobs_default();
    r_lat = 3;
    do_reset();
    saw_wait = 1'b0;
    for (int i = 0; i < 20 && !saw_wait; i++) begin
      @(negedge clk);
      #2;
      saw_wait = imem_rready;
    end
    chk1("t6_reached_wait", saw_wait, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("t6_arvalid_drop", imem_arvalid, 1'b0);
    chk1("t6_rready_drop", imem_rready, 1'b0);
    chk1("t6_ivalid_drop", ivalid, 1'b0);
    r_lat = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    run(10);
    chk32("t6_restart_addr", ar_log.size() > 0 ? ar_log[0] : 32'hffff_ffff, 32'h8000_0000);
    chk32("t6_restart_pc", iv_pc.size() > 0 ? iv_pc[0] : 32'hffff_ffff, 32'h8000_0000);
    chki("t6_restart_ivalid_cycle", iv_cyc.size() > 0 ? iv_cyc[0] : -1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
